// File: rtl/fusion_core_pkg.sv
// Shared execute-core types: width defaults, NOP encoding and the
// instruction record carried through the issue register.
package fusion_core_pkg;
  localparam int CORE_DATA_W = 32;
  localparam int CORE_REG_W  = 5;

  localparam logic [6:0] OP_ALU = 7'b0000000;
  localparam logic [5:0] AR_NOP = 6'b000000;

  typedef struct packed {
    logic [6:0]            op_code;
    logic [5:0]            ar_code;
    logic [CORE_REG_W-1:0] rd;
  } instr_t;

  function automatic logic is_nop(input logic [6:0] op, input logic [5:0] ar);
    return (op == OP_ALU) && (ar == AR_NOP);
  endfunction
endpackage

// File: rtl/alu_fwd_mux.sv
// Operand source select: r0, youngest in-flight result (E), older result (W),
// or register-file read data.
module alu_fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic [REG_W-1:0]  rs,
  input  logic              e_valid,
  input  logic [REG_W-1:0]  e_rd,
  input  logic              w_valid,
  input  logic [REG_W-1:0]  w_rd,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] w_data,
  input  logic [DATA_W-1:0] dec_data,
  output logic [DATA_W-1:0] operand
);
  always_comb begin
    operand = dec_data;
    if (rs == '0)                      operand = '0;
    else if (e_valid && rs == e_rd)    operand = alu_out;
    else if (w_valid && rs == w_rd)    operand = w_data;
  end
endmodule

// File: rtl/alu_issue_stage.sv
// Two-entry execute pipeline (issue reg E -> result reg W) around an external
// combinational ALU, with forwarding so dependent ops issue back to back.
module alu_issue_stage
  import fusion_core_pkg::*;
#(
  parameter int DATA_W = CORE_DATA_W,
  parameter int REG_W  = CORE_REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [6:0]        dec_op_code,
  input  logic [5:0]        dec_ar_code,
  input  logic [REG_W-1:0]  dec_rs_a,
  input  logic [REG_W-1:0]  dec_rs_b,
  input  logic [REG_W-1:0]  dec_rd,
  input  logic [DATA_W-1:0] dec_data_a,
  input  logic [DATA_W-1:0] dec_data_b,
  output logic [DATA_W-1:0] alu_op_a,
  output logic [DATA_W-1:0] alu_op_b,
  output logic [6:0]        alu_op_code,
  output logic [5:0]        alu_ar_code,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_flag_carry,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_carry
);
  localparam int NUM_SRC = 2;

  logic              e_valid, w_valid;
  instr_t            e_ins;
  logic [DATA_W-1:0] e_a, e_b;
  logic [REG_W-1:0]  w_rd;
  logic [DATA_W-1:0] w_data;
  logic              w_carry;

  logic w_adv, e_adv, accept, load_e;

  assign w_adv     = !w_valid || wb_ready;
  assign e_adv     = e_valid && w_adv;
  assign dec_ready = !flush && (!e_valid || w_adv);
  assign accept    = dec_valid && dec_ready;
  assign load_e    = accept && !is_nop(dec_op_code, dec_ar_code);

  logic [NUM_SRC-1:0][REG_W-1:0]  src_rs;
  logic [NUM_SRC-1:0][DATA_W-1:0] src_dec, src_sel;

  assign src_rs  = {dec_rs_b, dec_rs_a};
  assign src_dec = {dec_data_b, dec_data_a};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    alu_fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd (
      .rs       (src_rs[i]),
      .e_valid  (e_valid),
      .e_rd     (e_ins.rd),
      .w_valid  (w_valid),
      .w_rd     (w_rd),
      .alu_out  (alu_out),
      .w_data   (w_data),
      .dec_data (src_dec[i]),
      .operand  (src_sel[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid <= 1'b0;
      e_ins   <= '0;
      e_a     <= '0;
      e_b     <= '0;
    end else if (flush) begin
      e_valid <= 1'b0;
    end else if (load_e) begin
      e_valid <= 1'b1;
      e_ins   <= '{op_code: dec_op_code, ar_code: dec_ar_code, rd: dec_rd};
      e_a     <= src_sel[0];
      e_b     <= src_sel[1];
    end else if (e_adv) begin
      e_valid <= 1'b0;
    end
  end

  // A wb handshake in the flush cycle completes; flush only drops the entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid <= 1'b0;
      w_rd    <= '0;
      w_data  <= '0;
      w_carry <= 1'b0;
    end else if (flush) begin
      w_valid <= 1'b0;
    end else if (e_adv) begin
      w_valid <= 1'b1;
      w_rd    <= e_ins.rd;
      w_data  <= alu_out;
      w_carry <= alu_flag_carry;
    end else if (wb_ready) begin
      w_valid <= 1'b0;
    end
  end

  // Idle E presents a NOP so the ALU output is quiet.
  assign alu_op_code = e_valid ? e_ins.op_code : '0;
  assign alu_ar_code = e_valid ? e_ins.ar_code : '0;
  assign alu_op_a    = e_valid ? e_a : '0;
  assign alu_op_b    = e_valid ? e_b : '0;

  assign wb_valid = w_valid;
  assign wb_rd    = w_rd;
  assign wb_data  = w_data;
  assign wb_carry = w_carry;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small adder standing in for the ALU.
module tb_alu_issue_stage;
  localparam logic [5:0] AR_ADD = 6'd1;

  logic        clk = 1'b0;
  logic        rst_n, flush, dec_valid, wb_ready;
  logic [6:0]  dec_op_code, alu_op_code;
  logic [5:0]  dec_ar_code, alu_ar_code;
  logic [4:0]  dec_rs_a, dec_rs_b, dec_rd, wb_rd;
  logic [31:0] dec_data_a, dec_data_b, alu_op_a, alu_op_b, alu_out, wb_data;
  logic        dec_ready, alu_flag_carry, wb_valid, wb_carry;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    {alu_flag_carry, alu_out} = 33'd0;
    if (alu_op_code == 7'd0 && alu_ar_code == AR_ADD)
      {alu_flag_carry, alu_out} = {1'b0, alu_op_a} + {1'b0, alu_op_b};
  end

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_op_code(dec_op_code), .dec_ar_code(dec_ar_code),
    .dec_rs_a(dec_rs_a), .dec_rs_b(dec_rs_b), .dec_rd(dec_rd),
    .dec_data_a(dec_data_a), .dec_data_b(dec_data_b),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
    .alu_op_code(alu_op_code), .alu_ar_code(alu_ar_code),
    .alu_out(alu_out), .alu_flag_carry(alu_flag_carry),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_carry(wb_carry)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [4:0] rd, input logic [4:0] rsa, input logic [4:0] rsb,
                       input logic [31:0] da, input logic [31:0] db, input logic [5:0] ar);
    dec_valid   = 1'b1;
    dec_op_code = 7'd0;
    dec_ar_code = ar;
    dec_rd      = rd;
    dec_rs_a    = rsa;
    dec_rs_b    = rsb;
    dec_data_a  = da;
    dec_data_b  = db;
  endtask

  task automatic idle();
    dec_valid = 1'b0;
  endtask

  task automatic chk_wb(input string tag, input logic [4:0] rd, input logic [31:0] data);
    chk({tag, "_v"},  wb_valid, 1);
    chk({tag, "_rd"}, wb_rd, rd);
    chk({tag, "_d"},  wb_data, data);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; wb_ready = 1'b1;
    offer(0, 0, 0, 0, 0, 0);
    idle();
    #2;
    chk("rst_wbv", wb_valid, 0);
    chk("rst_rdy", dec_ready, 1);
    chk("rst_opc", alu_op_code, 0);
    chk("rst_ar",  alu_ar_code, 0);
    chk("rst_wbd", wb_data, 0);
    chk("rst_opa", alu_op_a, 0);
    #10 rst_n = 1'b1;
    step();

    // Independent stream: 12 then 7 on consecutive cycles
    offer(1, 10, 11, 5, 7, AR_ADD);
    step();
    chk("lat_e", wb_valid, 0);
    chk("e_opa", alu_op_a, 5);
    offer(2, 12, 13, 3, 4, AR_ADD);
    step();
    idle();
    chk_wb("s1", 1, 12);
    step();
    chk_wb("s2", 2, 7);
    step();
    chk("s_drain", wb_valid, 0);

    // E forwarding with stale register-file data
    offer(1, 10, 11, 5, 7, AR_ADD);
    step();
    offer(3, 1, 14, 0, 1, AR_ADD);
    step();
    idle();
    chk_wb("ef1", 1, 12);
    step();
    chk_wb("ef2", 3, 13);
    step();

    // E beats W when both hold the same rd
    offer(1, 10, 11, 5, 7, AR_ADD);
    step();
    offer(1, 12, 13, 1, 1, AR_ADD);
    step();
    offer(3, 1, 14, 0, 1, AR_ADD);
    step();
    idle();
    chk_wb("pri1", 1, 2);
    step();
    chk_wb("pri2", 3, 3);
    step();

    // W forwarding for rs_a, r0 forced to zero for rs_b
    offer(1, 10, 11, 4, 5, AR_ADD);
    step();
    offer(5, 12, 13, 1, 1, AR_ADD);
    step();
    offer(6, 1, 0, 0, 32'hFFFF_FFFF, AR_ADD);
    step();
    idle();
    chk_wb("wf1", 5, 2);
    step();
    chk_wb("wf2", 6, 9);
    step();

    // Back-pressure: two held, third stalled, then in-order delivery
    wb_ready = 1'b0;
    offer(7, 12, 13, 1, 2, AR_ADD);
    chk("bp_rdy0", dec_ready, 1);
    step();
    offer(8, 12, 13, 2, 2, AR_ADD);
    chk("bp_rdy1", dec_ready, 1);
    step();
    offer(9, 12, 13, 3, 3, AR_ADD);
    chk("bp_rdy2", dec_ready, 0);
    chk_wb("bp_h1", 7, 3);
    step();
    chk("bp_rdy3", dec_ready, 0);
    chk_wb("bp_h2", 7, 3);
    wb_ready = 1'b1;
    #1;
    chk("bp_rel", dec_ready, 1);
    step();
    idle();
    chk_wb("bp_o2", 8, 4);
    step();
    chk_wb("bp_o3", 9, 6);
    step();
    chk("bp_end", wb_valid, 0);

    // NOP accepted but never loaded
    offer(4, 12, 13, 1, 1, 6'd0);
    chk("nop_rdy", dec_ready, 1);
    step();
    idle();
    chk("nop_e", alu_ar_code, 0);
    step();
    chk("nop_wb", wb_valid, 0);

    // Flush with E and W full; offered instruction in flush cycle is refused
    wb_ready = 1'b0;
    offer(10, 12, 13, 1, 1, AR_ADD);
    step();
    offer(11, 12, 13, 1, 2, AR_ADD);
    step();
    chk("fl_full", wb_valid, 1);
    offer(12, 12, 13, 2, 2, AR_ADD);
    flush = 1'b1;
    #1;
    chk("fl_rdy", dec_ready, 0);
    step();
    flush = 1'b0;
    idle();
    chk("fl_w", wb_valid, 0);
    chk("fl_e", alu_ar_code, 0);
    wb_ready = 1'b1;
    step();
    chk("fl_none", wb_valid, 0);

    // Carry out
    offer(13, 12, 13, 32'hFFFF_FFFF, 1, AR_ADD);
    step();
    idle();
    step();
    chk_wb("cy", 13, 0);
    chk("cy_c", wb_carry, 1);
    step();

    // Asynchronous reset mid-stream with both entries full
    wb_ready = 1'b0;
    offer(14, 12, 13, 1, 1, AR_ADD);
    step();
    offer(15, 12, 13, 2, 1, AR_ADD);
    step();
    #3 rst_n = 1'b0;
    #1;
    chk("mr_wbv", wb_valid, 0);
    chk("mr_rdy", dec_ready, 1);
    chk("mr_ar",  alu_ar_code, 0);
    chk("mr_wbd", wb_data, 0);
    #1 rst_n = 1'b1;
    wb_ready = 1'b1;
    offer(16, 12, 13, 20, 22, AR_ADD);
    step();
    idle();
    chk("mr_lat", wb_valid, 0);
    step();
    chk_wb("mr_first", 16, 42);
    step();
    chk("mr_end", wb_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Two-entry execute pipeline wrapped around the combinational ALU: an issue register (E) that presents operands and codes to the ALU, and a result register (W) that captures the ALU result and carry for register-file writeback. Sits between instruction decode (upstream) and register-file writeback (downstream). Provides valid/ready handshakes on both sides, back-pressure, flush, and operand forwarding from E and W, so back-to-back dependent ALU instructions issue at one per cycle.

## Interface
- DATA_W, 32, operand/result width
- REG_W, 5, register index width; register 0 reads as zero and is never a forwarding source
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline flush (E and W invalidated)
- dec_valid  in  1  decode offers an instruction
- dec_ready  out  1  stage accepts it this cycle
- dec_op_code  in  7  op code
- dec_ar_code  in  6  arithmetic code
- dec_rs_a, dec_rs_b  in  REG_W  source indices
- dec_rd  in  REG_W  destination index
- dec_data_a, dec_data_b  in  DATA_W  register-file read data
- alu_op_a, alu_op_b  out  DATA_W  to ALU
- alu_op_code  out  7  to ALU
- alu_ar_code  out  6  to ALU
- alu_out  in  DATA_W  ALU result (combinational from alu_* outputs)
- alu_flag_carry  in  1  ALU carry
- wb_valid  out  1  result available
- wb_ready  in  1  writeback accepts
- wb_rd  out  REG_W  destination
- wb_data  out  DATA_W  result
- wb_carry  out  1  carry flag of result

## Operation
- Accept: dec_valid & dec_ready at a rising edge. Transfer out: wb_valid & wb_ready.
- w_adv = !w_valid | wb_ready; e_adv = e_valid & w_adv; dec_ready = !flush & (!e_valid | w_adv).
- NOP (op_code 0, ar_code 0): accepted (handshake completes) but not loaded into E; produces no writeback.
- On accept, E loads op_code, ar_code, rd and operands A/B, each selected per source:
  - rs == 0 -> 0;
  - else e_valid & rs == e_rd -> alu_out (E has priority, youngest);
  - else w_valid & rs == w_rd -> w_data;
  - else dec_data.
- When e_adv, W loads e_rd, alu_out, alu_flag_carry; w_valid <= 1. If W drains with no E advance, w_valid <= 0.
- E: e_valid <= 1 on non-NOP accept, else 0 if e_adv, else hold.
- While e_valid = 0, alu_op_code and alu_ar_code read 0 and alu_op_a/b read 0, so the ALU sees a NOP.
- Flush: next edge e_valid = w_valid = 0. No decode accept in the flush cycle. A wb handshake in the flush cycle still counts as completed.
- Reset (rst_n low, asynchronous): e_valid = w_valid = 0; all E/W data registers 0. Outputs: wb_valid = 0, wb_rd/wb_data/wb_carry = 0, alu_* = 0, dec_ready = 1 (once flush is low).
- Reset asserted mid-operation discards both entries immediately. No partial writeback is emitted.

## Timing
- Accept at edge N -> ALU inputs driven during cycle N..N+1 -> wb_valid high after edge N+1. Latency 2 edges, throughput 1 per cycle.
- Back-pressure: wb_ready low with W full and E full -> dec_ready low the same cycle (combinational from wb_ready).
- dec_ready depends combinationally on wb_ready and flush only. Accept, forwarding and advance all resolve at the same edge.
- Dependency on a result leaving W at the same edge it enters E: forwarded from w_data (register file write not yet visible).

## Structure
- Shared package fusion_core_pkg holds:
  - DATA_W and REG_W defaults;
  - OP_ALU = 7'b0000000 and AR_NOP = 6'b000000;
  - an instruction record typedef: op_code, ar_code, rd.
- Sub-module alu_fwd_mux, instantiated once per operand: inputs rs, E/W valid+rd, alu_out, w_data, dec_data; output selected operand.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- Reset: rst_n low mid-stream with E and W full -> wb_valid = 0, dec_ready = 1, alu_op_code = 0 immediately. First accept after release gives wb_valid 2 edges later.
- Stream without hazard: ADD r1 = 5+7, then r2 = 3+4, wb_ready = 1 -> wb_data 12 then 7 on consecutive cycles, rd 1 then 2.
- E forwarding: r1 = 5+7, next cycle r3 = r1+1 with dec_data_a = 0 (stale) -> wb_data 13.
- W forwarding and r0: r1 = 9 (two cycles earlier) used as rs_a, rs_b = 0 with dec_data_b = 0xFFFF_FFFF -> operand b = 0, result 9.
- Back-pressure: hold wb_ready = 0 for 3 cycles with 3 offered instructions -> two held, dec_ready = 0, wb_data stable. Release -> both delivered in order, none lost or duplicated.
- NOP, flush and carry:
  - NOP accepted -> no wb_valid;
  - flush with E/W full -> both cleared next edge;
  - 0xFFFF_FFFF + 1 -> wb_data 0, wb_carry 1.
